// File: rtl/vector_to_angle.sv
// vector_to_angle: iterative CORDIC vectoring that turns a signed (dx,dy) screen vector
// (+y down) into a 2^COUNT_SIZE-step angle index, with a start/valid handshake.
// Ports: clk, resetN (async, active-low), start, dx, dy in; busy, valid, angle, zero_vec, mag out.
// Optional macro VECTOR_ANGLE_MAG_EN adds the gain-compensated magnitude on mag; otherwise mag=0.
`timescale 1ns/1ps
module vector_to_angle #(
  parameter int COUNT_SIZE = 8,
  parameter int DATA_W     = 16,
  parameter int ITER       = 12
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] dx,
  input  logic signed [DATA_W-1:0] dy,
  output logic                     busy,
  output logic                     valid,
  output logic [COUNT_SIZE-1:0]    angle,
  output logic                     zero_vec,
  output logic [DATA_W:0]          mag
);

  localparam int XW = DATA_W + 2;
  localparam int AW = COUNT_SIZE + 8;
  localparam int IW = $clog2(ITER + 1);
  localparam int UP = (COUNT_SIZE >= 8) ? COUNT_SIZE - 8 : 0;
  localparam int DN = (COUNT_SIZE < 8) ? 8 - COUNT_SIZE : 0;
  localparam logic [AW-1:0] HALF = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  // atan(2^-k) in 1/2^(COUNT_SIZE+8) turn, rescaled from the 8-bit table
  function automatic logic [AW-1:0] atan_lut(input logic [IW-1:0] k);
    int unsigned b;
    case (int'(k))
      0:       b = 8192;
      1:       b = 4836;
      2:       b = 2555;
      3:       b = 1297;
      4:       b = 651;
      5:       b = 326;
      6:       b = 163;
      7:       b = 81;
      8:       b = 41;
      9:       b = 20;
      10:      b = 10;
      11:      b = 5;
      default: b = 0;
    endcase
    return AW'(((b << UP) + ((32'd1 << DN) >> 1)) >> DN);
  endfunction

  state_t                 state_q, state_d;
  logic signed [XW-1:0]   x_q, x_d;
  logic signed [XW-1:0]   y_q, y_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [IW-1:0]          i_q, i_d;
  logic                   zero_q, zero_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [COUNT_SIZE-1:0]  angle_q, angle_d;
  logic                   zv_q, zv_d;

  logic signed [XW-1:0]   dxe, dye;
  logic signed [XW-1:0]   xs, ys;
  logic [AW-1:0]          a_i;

  assign dxe = {{2{dx[DATA_W-1]}}, dx};
  assign dye = {{2{dy[DATA_W-1]}}, dy};
  assign xs  = x_q >>> i_q;
  assign ys  = y_q >>> i_q;
  assign a_i = atan_lut(i_q);

`ifdef VECTOR_ANGLE_MAG_EN
  localparam int PW = XW - 1 + 16;
  localparam int MW = DATA_W + 1;
  localparam logic [15:0] MAG_K = 16'd39797;

  logic [DATA_W:0] mag_q, mag_d;
  logic [PW-1:0]   prod;

  // x stays non-negative after the half-turn pre-rotation
  assign prod = PW'(x_q[XW-2:0]) * PW'(MAG_K);
  assign mag  = mag_q;
`else
  assign mag  = '0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    i_d     = i_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    angle_d = angle_q;
    zv_d    = zv_q;
`ifdef VECTOR_ANGLE_MAG_EN
    mag_d   = mag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ITER;
          busy_d  = 1'b1;
          i_d     = '0;
          zero_d  = (dx == '0) && (dy == '0);
          // left half-plane: rotate by 180 deg so CORDIC converges
          if (dx[DATA_W-1]) begin
            x_d   = -dxe;
            y_d   = -dye;
            acc_d = HALF;
          end else begin
            x_d   = dxe;
            y_d   = dye;
            acc_d = '0;
          end
        end
      end
      S_ITER: begin
        if (!y_q[XW-1]) begin
          x_d   = x_q + ys;
          y_d   = y_q - xs;
          acc_d = acc_q + a_i;
        end else begin
          x_d   = x_q - ys;
          y_d   = y_q + xs;
          acc_d = acc_q - a_i;
        end
        if (i_q == IW'(ITER - 1)) begin
          state_d = S_DONE;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        zv_d    = zero_q;
        angle_d = zero_q ? '0
                : COUNT_SIZE'((acc_q + AW'(128)) >> 8);
`ifdef VECTOR_ANGLE_MAG_EN
        mag_d   = zero_q ? '0 : MW'(prod >> 16);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      angle_q <= '0;
      zv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      angle_q <= angle_d;
      zv_q    <= zv_d;
    end
  end

`ifdef VECTOR_ANGLE_MAG_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mag_q <= '0;
    end else begin
      mag_q <= mag_d;
    end
  end
`endif

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign angle    = angle_q;
  assign zero_vec = zv_q;

endmodule

// File: tb/tb_vector_to_angle.sv
// Bench for vector_to_angle: directed and random vectors, checked against
// an atan2/sqrt reference model with latency, ignore-while-busy and reset cases.
`timescale 1ns/1ps
module tb_vector_to_angle;

  localparam int CS = 8;
  localparam int DW = 16;
  localparam int IT = 12;
  localparam real PI = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 resetN = 1'b0;
  logic                 start = 1'b0;
  logic signed [DW-1:0] dx = '0;
  logic signed [DW-1:0] dy = '0;
  logic                 busy;
  logic                 valid;
  logic [CS-1:0]        angle;
  logic                 zero_vec;
  logic [DW:0]          mag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_to_angle #(
    .COUNT_SIZE(CS),
    .DATA_W(DW),
    .ITER(IT)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .start(start),
    .dx(dx),
    .dy(dy),
    .busy(busy),
    .valid(valid),
    .angle(angle),
    .zero_vec(zero_vec),
    .mag(mag)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ang(input string tag, input int obs, input int exp);
    int  d;
    logic ok;
    d  = (obs - exp + 512) % 256;
    ok = (d <= 1) || (d >= 255);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s angle got %0d exp %0d+-1", tag, obs, exp);
    end
  endtask

  function automatic int ref_angle(input int x, input int y);
    real r;
    int  k;
    r = $atan2(real'(y), real'(x)) * 256.0 / (2.0 * PI);
    k = int'(r);
    return ((k % 256) + 256) % 256;
  endfunction

  task automatic chk_mag(input string tag, input int vx, input int vy);
`ifdef VECTOR_ANGLE_MAG_EN
    int  m;
    int  tol;
    logic ok;
    m   = int'($sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy)));
    tol = (m / 500 > 2) ? m / 500 : 2;
    ok  = (int'(mag) >= m - tol) && (int'(mag) <= m + tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s mag got %0d exp %0d+-%0d", tag, mag, m, tol);
    end
`else
    chk({tag, ":mag0"}, mag, 0);
`endif
  endtask

  // start is raised in the current cycle; called right after a valid
  // sample this also exercises back-to-back acceptance
  task automatic run_vec(input int vx, input int vy, input int ea,
                         input string tag);
    int lat;
    bit z;
    z     = (vx == 0) && (vy == 0);
    dx    = DW'(vx);
    dy    = DW'(vy);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dx    = DW'($urandom);
    dy    = DW'($urandom);
    chk({tag, ":busy"}, busy, 1);
    chk({tag, ":vlow"}, valid, 0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, ":lat"}, lat, IT + 1);
    if (lat != 0) begin
      chk({tag, ":busy0"}, busy, 0);
      if (z) begin
        chk({tag, ":ang0"}, angle, 0);
        chk({tag, ":zv1"}, zero_vec, 1);
        chk({tag, ":mag0"}, mag, 0);
      end else begin
        chk_ang(tag, int'(angle), ea);
        chk({tag, ":zv0"}, zero_vec, 0);
        chk_mag(tag, vx, vy);
      end
    end
  endtask

  initial begin
    int nval;
    int vlat;
    int vang;
    int vx;
    int vy;
    longint m2;

    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", busy, 0);
    chk("rst:valid", valid, 0);
    chk("rst:angle", angle, 0);
    chk("rst:zv", zero_vec, 0);
    chk("rst:mag", mag, 0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    run_vec(100, 0, 0, "right");
    run_vec(0, 100, 64, "down");
    run_vec(-100, 0, 128, "left");
    run_vec(0, -100, 192, "up");
    run_vec(100, 100, 32, "diag");
    run_vec(-100, -100, 160, "diag_neg");
    run_vec(-32768, 0, 128, "min_x");
    run_vec(0, 0, 0, "zero");
    run_vec(-32768, -32768, 160, "min_xy");

    // second start 3 cycles after acceptance must be dropped
    dx    = 16'sd100;
    dy    = 16'sd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dx    = 16'sd0;
    dy    = 16'sd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nval  = 0;
    vlat  = 0;
    vang  = -1;
    for (int n = 4; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        nval++;
        if (nval == 1) begin
          vlat = n;
          vang = int'(angle);
        end
      end
    end
    chk("ign:count", nval, 1);
    chk("ign:lat", vlat, IT + 1);
    chk_ang("ign", vang, 0);

    // abort mid-iteration after leaving a non-zero result on the outputs
    run_vec(0, -100, 192, "pre_rst");
    dx    = 16'sd0;
    dy    = 16'sd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    chk("abort:busy", busy, 0);
    chk("abort:valid", valid, 0);
    chk("abort:angle", angle, 0);
    chk("abort:zv", zero_vec, 0);
    chk("abort:mag", mag, 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    nval = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (valid) nval++;
    end
    chk("abort:novalid", nval, 0);
    run_vec(-100, 0, 128, "post_rst");

    for (int r = 0; r < 24; r++) begin
      do begin
        if (r % 3 == 0) begin
          vx = int'($urandom_range(0, 4000)) - 2000;
          vy = int'($urandom_range(0, 4000)) - 2000;
        end else begin
          vx = int'(DW'($signed($urandom)));
          vy = int'(DW'($signed($urandom)));
          vx = (vx > 32767) ? vx - 65536 : vx;
          vy = (vy > 32767) ? vy - 65536 : vy;
        end
        m2 = longint'(vx) * vx + longint'(vy) * vy;
      end while (m2 < 65536);
      run_vec(vx, vy, ref_angle(vx, vy), "rand");
    end

    for (int k = 0; k < 256; k++) begin
      vx = int'(1000.0 * $cos(2.0 * PI * real'(k) / 256.0));
      vy = int'(1000.0 * $sin(2.0 * PI * real'(k) / 256.0));
      run_vec(vx, vy, k, "sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
